// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
//
// Two-port read arbiter and four-phase req/fin responder in front of a
// single-port synchronous RAM. Port 0 is the core load path, port 1 is the
// debug memory checker. Requests are served one at a time. When both ports
// request together, the port that was not granted last wins.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   rdN_req / rdN_addr    request level and byte address (N = 0, 1)
//   rdN_fin               completion level, held until rdN_req drops
//   rdN_data / rdN_err    read word and out-of-range flag, valid while rdN_fin
//   mem_en / mem_addr     one-cycle RAM read strobe and word address
//   mem_rdata             RAM read data, READ_LATENCY cycles after mem_en
//   busy                  high whenever the arbiter is not idle
//
// All outputs are registered.
module mem_read_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned READ_LATENCY = 1   // legal range 1..4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd0_req,
  input  logic [31:0]           rd0_addr,
  output logic                  rd0_fin,
  output logic [31:0]           rd0_data,
  output logic                  rd0_err,
  input  logic                  rd1_req,
  input  logic [31:0]           rd1_addr,
  output logic                  rd1_fin,
  output logic [31:0]           rd1_data,
  output logic                  rd1_err,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata,
  output logic                  busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_grant_q, last_grant_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  rd0_fin_q, rd0_fin_d;
  logic                  rd1_fin_q, rd1_fin_d;
  logic [31:0]           rd0_data_q, rd0_data_d;
  logic [31:0]           rd1_data_q, rd1_data_d;
  logic                  rd0_err_q, rd0_err_d;
  logic                  rd1_err_q, rd1_err_d;
  logic                  mem_en_q, mem_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  busy_q, busy_d;

  // Arbitration for the IDLE state: a lone request wins outright, a tie goes
  // to the port not granted last.
  logic        any_req;
  logic        pick;
  logic [31:0] pick_addr;
  logic        pick_oor;
  logic        gnt_req;

  assign any_req   = rd0_req | rd1_req;
  assign pick      = (rd0_req & rd1_req) ? ~last_grant_q : rd1_req;
  assign pick_addr = pick ? rd1_addr : rd0_addr;
  // Any byte-address bit above the RAM word range marks the access invalid.
  assign pick_oor  = |(pick_addr >> (ADDR_WIDTH + 2));
  assign gnt_req   = gnt_q ? rd1_req : rd0_req;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rd0_fin_d    = rd0_fin_q;
    rd1_fin_d    = rd1_fin_q;
    rd0_data_d   = rd0_data_q;
    rd1_data_d   = rd1_data_q;
    rd0_err_d    = rd0_err_q;
    rd1_err_d    = rd1_err_q;
    mem_en_d     = 1'b0;
    mem_addr_d   = mem_addr_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d = pick;
          if (pick_oor) begin
            // Out-of-range requests complete at once without touching the RAM.
            state_d = DONE;
            if (pick) begin
              rd1_data_d = '0;
              rd1_err_d  = 1'b1;
              rd1_fin_d  = 1'b1;
            end else begin
              rd0_data_d = '0;
              rd0_err_d  = 1'b1;
              rd0_fin_d  = 1'b1;
            end
          end else begin
            state_d    = ISSUE;
            mem_en_d   = 1'b1;
            mem_addr_d = pick_addr[ADDR_WIDTH+1:2];
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = LAT_LOAD;
      end
      WAIT: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          // Data is always captured; fin is withheld if the requester gave up.
          if (gnt_q) begin
            rd1_data_d = mem_rdata;
            rd1_err_d  = 1'b0;
            rd1_fin_d  = gnt_req;
          end else begin
            rd0_data_d = mem_rdata;
            rd0_err_d  = 1'b0;
            rd0_fin_d  = gnt_req;
          end
          if (gnt_req) begin
            state_d = DONE;
          end else begin
            state_d      = IDLE;
            last_grant_d = gnt_q;
          end
        end
      end
      DONE: begin
        if (!gnt_req) begin
          rd0_fin_d    = 1'b0;
          rd1_fin_d    = 1'b0;
          last_grant_d = gnt_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 2'd0;
      rd0_fin_q    <= 1'b0;
      rd1_fin_q    <= 1'b0;
      rd0_data_q   <= '0;
      rd1_data_q   <= '0;
      rd0_err_q    <= 1'b0;
      rd1_err_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rd0_fin_q    <= rd0_fin_d;
      rd1_fin_q    <= rd1_fin_d;
      rd0_data_q   <= rd0_data_d;
      rd1_data_q   <= rd1_data_d;
      rd0_err_q    <= rd0_err_d;
      rd1_err_q    <= rd1_err_d;
      mem_en_q     <= mem_en_d;
      mem_addr_q   <= mem_addr_d;
      busy_q       <= busy_d;
    end
  end

  assign rd0_fin  = rd0_fin_q;
  assign rd1_fin  = rd1_fin_q;
  assign rd0_data = rd0_data_q;
  assign rd1_data = rd1_data_q;
  assign rd0_err  = rd0_err_q;
  assign rd1_err  = rd1_err_q;
  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
module tb_mem_read_arbiter;

  localparam logic [31:0] DB  = 32'hDEADBEEF;
  localparam logic [31:0] BAD = 32'hBADBAD00;

  // RAM contents: word 4 holds DEADBEEF, every other word holds C0DE0 + index.
  function automatic logic [31:0] ramf(input logic [11:0] a);
    return (a == 12'd4) ? DB : {20'hC0DE0, a};
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // DUT a: READ_LATENCY = 1
  logic        a_req0, a_req1, a_fin0, a_fin1, a_err0, a_err1, a_mem_en, a_busy;
  logic [31:0] a_addr0, a_addr1, a_data0, a_data1, a_rdata;
  logic [11:0] a_mem_addr;
  // DUT b: READ_LATENCY = 3
  logic        b_req0, b_req1, b_fin0, b_fin1, b_err0, b_err1, b_mem_en, b_busy;
  logic [31:0] b_addr0, b_addr1, b_data0, b_data1, b_rdata;
  logic [11:0] b_mem_addr;

  mem_read_arbiter #(.ADDR_WIDTH(12), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset),
    .rd0_req(a_req0), .rd0_addr(a_addr0), .rd0_fin(a_fin0), .rd0_data(a_data0), .rd0_err(a_err0),
    .rd1_req(a_req1), .rd1_addr(a_addr1), .rd1_fin(a_fin1), .rd1_data(a_data1), .rd1_err(a_err1),
    .mem_en(a_mem_en), .mem_addr(a_mem_addr), .mem_rdata(a_rdata), .busy(a_busy)
  );

  mem_read_arbiter #(.ADDR_WIDTH(12), .READ_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset),
    .rd0_req(b_req0), .rd0_addr(b_addr0), .rd0_fin(b_fin0), .rd0_data(b_data0), .rd0_err(b_err0),
    .rd1_req(b_req1), .rd1_addr(b_addr1), .rd1_fin(b_fin1), .rd1_data(b_data1), .rd1_err(b_err1),
    .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_rdata(b_rdata), .busy(b_busy)
  );

  // RAM models; non-strobed cycles load a marker so mistimed captures show up.
  logic [31:0] a_p1, b_p1, b_p2, b_p3;
  always @(posedge clk) begin
    a_p1 <= a_mem_en ? ramf(a_mem_addr) : BAD;
    b_p1 <= b_mem_en ? ramf(b_mem_addr) : BAD;
    b_p2 <= b_p1;
    b_p3 <= b_p2;
  end
  assign a_rdata = a_p1;
  assign b_rdata = b_p3;

  typedef struct {
    logic        rst, q0, q1;
    logic [31:0] a0, a1;
    logic        f0, f1, e0, e1, en, bsy;
    logic [31:0] d0, d1;
    logic        ck;
    logic [11:0] ma;
  } vec_t;

  function automatic vec_t mk(input logic rst, q0, input logic [31:0] a0, input logic q1,
                              input logic [31:0] a1, input logic f0, f1, e0, e1, en, bsy,
                              input logic [31:0] d0, d1, input logic ck, input logic [11:0] ma);
    vec_t v;
    v.rst = rst; v.q0 = q0; v.a0 = a0; v.q1 = q1; v.a1 = a1;
    v.f0 = f0; v.f1 = f1; v.e0 = e0; v.e1 = e1; v.en = en; v.bsy = bsy;
    v.d0 = d0; v.d1 = d1; v.ck = ck; v.ma = ma;
    return v;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t vq[$];

  initial begin
    logic [31:0] w2, w8, w9, wa, wb, wc, wf;
    logic [69:0] act, exp;
    w2 = ramf(12'd2);  w8 = ramf(12'd8);  w9 = ramf(12'd9); wa = ramf(12'd10);
    wb = ramf(12'd11); wc = ramf(12'd12); wf = ramf(12'hFFF);
    //                  rst q0 a0        q1 a1       f0 f1 e0 e1 en by d0  d1  ck ma
    vq.push_back(mk(1, 0, 0,        0, 0,       0, 0, 0, 0, 0, 0, 0,  0,  1, 0));
    // port 1 reads 0x10
    vq.push_back(mk(0, 0, 0,        1, 'h10,    0, 0, 0, 0, 1, 1, 0,  0,  1, 4));
    vq.push_back(mk(0, 0, 0,        1, 'h10,    0, 0, 0, 0, 0, 1, 0,  0,  0, 0));
    vq.push_back(mk(0, 0, 0,        1, 'h10,    0, 1, 0, 0, 0, 1, 0,  DB, 0, 0));
    vq.push_back(mk(0, 0, 0,        1, 'h10,    0, 1, 0, 0, 0, 1, 0,  DB, 0, 0));
    vq.push_back(mk(0, 0, 0,        0, 'h10,    0, 0, 0, 0, 0, 0, 0,  DB, 0, 0));
    // tie: port 0 first, then port 1, then alternate
    vq.push_back(mk(0, 1, 'h20,     1, 'h24,    0, 0, 0, 0, 1, 1, 0,  DB, 1, 8));
    vq.push_back(mk(0, 1, 'h20,     1, 'h24,    0, 0, 0, 0, 0, 1, 0,  DB, 0, 0));
    vq.push_back(mk(0, 1, 'h20,     1, 'h24,    1, 0, 0, 0, 0, 1, w8, DB, 0, 0));
    vq.push_back(mk(0, 0, 'h20,     1, 'h24,    0, 0, 0, 0, 0, 0, w8, DB, 0, 0));
    vq.push_back(mk(0, 0, 'h20,     1, 'h24,    0, 0, 0, 0, 1, 1, w8, DB, 1, 9));
    vq.push_back(mk(0, 0, 'h20,     1, 'h24,    0, 0, 0, 0, 0, 1, w8, DB, 0, 0));
    vq.push_back(mk(0, 0, 'h20,     1, 'h24,    0, 1, 0, 0, 0, 1, w8, w9, 0, 0));
    vq.push_back(mk(0, 1, 'h28,     0, 'h24,    0, 0, 0, 0, 0, 0, w8, w9, 0, 0));
    vq.push_back(mk(0, 1, 'h28,     1, 'h24,    0, 0, 0, 0, 1, 1, w8, w9, 1, 10));
    vq.push_back(mk(0, 1, 'h28,     1, 'h24,    0, 0, 0, 0, 0, 1, w8, w9, 0, 0));
    vq.push_back(mk(0, 1, 'h28,     1, 'h24,    1, 0, 0, 0, 0, 1, wa, w9, 0, 0));
    vq.push_back(mk(0, 0, 'h28,     1, 'h2C,    0, 0, 0, 0, 0, 0, wa, w9, 0, 0));
    vq.push_back(mk(0, 1, 'h28,     1, 'h2C,    0, 0, 0, 0, 1, 1, wa, w9, 1, 11));
    vq.push_back(mk(0, 1, 'h28,     1, 'h2C,    0, 0, 0, 0, 0, 1, wa, w9, 0, 0));
    vq.push_back(mk(0, 1, 'h28,     1, 'h2C,    0, 1, 0, 0, 0, 1, wa, wb, 0, 0));
    vq.push_back(mk(0, 0, 'h28,     0, 'h2C,    0, 0, 0, 0, 0, 0, wa, wb, 0, 0));
    // out of range, then the highest in-range (misaligned) address
    vq.push_back(mk(0, 1, 'h4000,   0, 0,       1, 0, 1, 0, 0, 1, 0,  wb, 0, 0));
    vq.push_back(mk(0, 1, 'h4000,   0, 0,       1, 0, 1, 0, 0, 1, 0,  wb, 0, 0));
    vq.push_back(mk(0, 0, 'h4000,   0, 0,       0, 0, 1, 0, 0, 0, 0,  wb, 0, 0));
    vq.push_back(mk(0, 1, 'h3FFF,   0, 0,       0, 0, 1, 0, 1, 1, 0,  wb, 1, 12'hFFF));
    vq.push_back(mk(0, 1, 'h3FFF,   0, 0,       0, 0, 1, 0, 0, 1, 0,  wb, 0, 0));
    vq.push_back(mk(0, 1, 'h3FFF,   0, 0,       1, 0, 0, 0, 0, 1, wf, wb, 0, 0));
    vq.push_back(mk(0, 0, 'h3FFF,   0, 0,       0, 0, 0, 0, 0, 0, wf, wb, 0, 0));
    // port 1 abandons during WAIT: data updates, no fin
    vq.push_back(mk(0, 0, 0,        1, 'h30,    0, 0, 0, 0, 1, 1, wf, wb, 1, 12));
    vq.push_back(mk(0, 0, 0,        0, 'h30,    0, 0, 0, 0, 0, 1, wf, wb, 0, 0));
    vq.push_back(mk(0, 0, 0,        0, 'h30,    0, 0, 0, 0, 0, 0, wf, wc, 0, 0));
    vq.push_back(mk(0, 0, 0,        1, 'h10,    0, 0, 0, 0, 1, 1, wf, wc, 1, 4));
    vq.push_back(mk(0, 0, 0,        1, 'h10,    0, 0, 0, 0, 0, 1, wf, wc, 0, 0));
    vq.push_back(mk(0, 0, 0,        1, 'h10,    0, 1, 0, 0, 0, 1, wf, DB, 0, 0));
    vq.push_back(mk(0, 0, 0,        0, 'h10,    0, 0, 0, 0, 0, 0, wf, DB, 0, 0));
    // reset during WAIT, then a clean port 0 read
    vq.push_back(mk(0, 1, 'h8,      0, 0,       0, 0, 0, 0, 1, 1, wf, DB, 1, 2));
    vq.push_back(mk(0, 1, 'h8,      0, 0,       0, 0, 0, 0, 0, 1, wf, DB, 0, 0));
    vq.push_back(mk(1, 1, 'h8,      0, 0,       0, 0, 0, 0, 0, 0, 0,  0,  1, 0));
    vq.push_back(mk(0, 1, 'h8,      0, 0,       0, 0, 0, 0, 1, 1, 0,  0,  1, 2));
    vq.push_back(mk(0, 1, 'h8,      0, 0,       0, 0, 0, 0, 0, 1, 0,  0,  0, 0));
    vq.push_back(mk(0, 1, 'h8,      0, 0,       1, 0, 0, 0, 0, 1, w2, 0,  0, 0));
    vq.push_back(mk(0, 0, 'h8,      0, 0,       0, 0, 0, 0, 0, 0, w2, 0,  0, 0));

    reset = 1'b1;
    a_req0 = 0; a_req1 = 0; a_addr0 = 0; a_addr1 = 0;
    b_req0 = 0; b_req1 = 0; b_addr0 = 0; b_addr1 = 0;
    @(negedge clk);

    foreach (vq[i]) begin
      reset  = vq[i].rst;
      a_req0 = vq[i].q0; a_addr0 = vq[i].a0;
      a_req1 = vq[i].q1; a_addr1 = vq[i].a1;
      @(posedge clk);
      @(negedge clk);
      act = {a_fin0, a_fin1, a_err0, a_err1, a_mem_en, a_busy, a_data0, a_data1};
      exp = {vq[i].f0, vq[i].f1, vq[i].e0, vq[i].e1, vq[i].en, vq[i].bsy, vq[i].d0, vq[i].d1};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL row %0d outputs {fin0,fin1,err0,err1,mem_en,busy,data0,data1}: got %h expected %h",
                 i, act, exp);
      end
      if (vq[i].ck) chk($sformatf("row %0d mem_addr", i), 32'(a_mem_addr), 32'(vq[i].ma));
    end

    // READ_LATENCY=3, misaligned address 0x7: fin from cycle 5 with word 1.
    b_req0 = 1'b1; b_addr0 = 32'h7;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("lat3 cycle %0d mem_en", c), 32'(b_mem_en), 32'(c == 1));
      if (c == 1) chk("lat3 mem_addr", 32'(b_mem_addr), 32'd1);
      chk($sformatf("lat3 cycle %0d fin0", c), 32'(b_fin0), 32'(c >= 5));
      chk($sformatf("lat3 cycle %0d fin1", c), 32'(b_fin1), 32'd0);
      if (c >= 5) begin
        chk("lat3 data0", b_data0, ramf(12'd1));
        chk("lat3 err0", 32'(b_err0), 32'd0);
      end
    end
    b_req0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("lat3 fin0 after release", 32'(b_fin0), 32'd0);
    chk("lat3 busy after release", 32'(b_busy), 32'd0);
    chk("lat3 data0 held", b_data0, ramf(12'd1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
